// File: rtl/psram_req_arbiter_if.sv
// Bundle of the two requester ports and the PSRAM controller native port.
interface psram_req_arbiter_if #(
    parameter int unsigned AW = 24
);
    // Requester M0 (data)
    logic          m0_req;
    logic          m0_wr;
    logic [AW-1:0] m0_addr;
    logic [2:0]    m0_size;
    logic [31:0]   m0_wdata;
    logic [31:0]   m0_rdata;
    logic          m0_done;

    // Requester M1 (instruction fetch)
    logic          m1_req;
    logic          m1_wr;
    logic [AW-1:0] m1_addr;
    logic [2:0]    m1_size;
    logic [31:0]   m1_wdata;
    logic [31:0]   m1_rdata;
    logic          m1_done;

    // Controller native port
    logic          ctrl_start;
    logic          ctrl_wr;
    logic [AW-1:0] ctrl_addr;
    logic [2:0]    ctrl_size;
    logic [31:0]   ctrl_wdata;
    logic [31:0]   ctrl_rdata;
    logic          ctrl_done;

    // Status
    logic          busy;
    logic          owner;

    // Arbiter side
    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_size, m0_wdata,
        output m0_rdata, m0_done,
        input  m1_req, m1_wr, m1_addr, m1_size, m1_wdata,
        output m1_rdata, m1_done,
        output ctrl_start, ctrl_wr, ctrl_addr, ctrl_size, ctrl_wdata,
        input  ctrl_rdata, ctrl_done,
        output busy, owner
    );

    // Requester/controller side
    modport master (
        output m0_req, m0_wr, m0_addr, m0_size, m0_wdata,
        input  m0_rdata, m0_done,
        output m1_req, m1_wr, m1_addr, m1_size, m1_wdata,
        input  m1_rdata, m1_done,
        input  ctrl_start, ctrl_wr, ctrl_addr, ctrl_size, ctrl_wdata,
        output ctrl_rdata, ctrl_done,
        input  busy, owner
    );
endinterface

// File: rtl/psram_req_arbiter.sv
// Two-requester arbiter/sequencer in front of the PSRAM controller native port.
// Latches the winning request, issues one start pulse, waits for done, returns
// data and a done pulse to the owner, then enforces an idle gap before the next grant.
module psram_req_arbiter #(
    parameter int unsigned AW         = 24,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned FIXED_PRIO = 0
) (
    input logic               clk,
    input logic               rst,
    psram_req_arbiter_if.slave bus
);

    localparam int unsigned GapInit = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [3:0]  GapLoad = GapInit[3:0];

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

    state_e        state_q;
    logic [3:0]    gap_cnt_q;
    logic          rr_last_q;
    logic          owner_q;
    logic          ctrl_start_q;
    logic          ctrl_wr_q;
    logic [AW-1:0] ctrl_addr_q;
    logic [2:0]    ctrl_size_q;
    logic [31:0]   ctrl_wdata_q;
    logic [31:0]   m0_rdata_q;
    logic [31:0]   m1_rdata_q;
    logic          m0_done_q;
    logic          m1_done_q;

    logic          elig0;
    logic          elig1;
    logic          winner;
    logic          accept;

    // A requester whose done is currently pulsing has not yet had a chance to drop req.
    assign elig0 = bus.m0_req & ~m0_done_q;
    assign elig1 = bus.m1_req & ~m1_done_q;

    // Done arriving in the start cycle is honoured exactly like one arriving in WAIT.
    assign accept = bus.ctrl_done & ((state_q == StIssue) | (state_q == StWait));

    // Winner selection: fixed priority to M0, or round-robin away from the last grant.
    always_comb begin
        winner = 1'b0;
        if (elig0 && elig1) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~rr_last_q;
        end else if (elig1) begin
            winner = 1'b1;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            gap_cnt_q    <= 4'd0;
            rr_last_q    <= 1'b1;
            owner_q      <= 1'b0;
            ctrl_start_q <= 1'b0;
            ctrl_wr_q    <= 1'b0;
            ctrl_addr_q  <= '0;
            ctrl_size_q  <= 3'd0;
            ctrl_wdata_q <= 32'd0;
            m0_rdata_q   <= 32'd0;
            m1_rdata_q   <= 32'd0;
            m0_done_q    <= 1'b0;
            m1_done_q    <= 1'b0;
        end else begin
            ctrl_start_q <= 1'b0;
            m0_done_q    <= 1'b0;
            m1_done_q    <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (elig0 || elig1) begin
                        state_q      <= StIssue;
                        ctrl_start_q <= 1'b1;
                        owner_q      <= winner;
                        rr_last_q    <= winner;
                        ctrl_wr_q    <= winner ? bus.m1_wr    : bus.m0_wr;
                        ctrl_addr_q  <= winner ? bus.m1_addr  : bus.m0_addr;
                        ctrl_size_q  <= winner ? bus.m1_size  : bus.m0_size;
                        ctrl_wdata_q <= winner ? bus.m1_wdata : bus.m0_wdata;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    state_q <= StWait;
                end
                StGap: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            // Completion overrides the ISSUE->WAIT step above.
            if (accept) begin
                state_q   <= (GAP_CYCLES == 0) ? StIdle : StGap;
                gap_cnt_q <= GapLoad;
                if (owner_q) begin
                    m1_done_q <= 1'b1;
                    if (!ctrl_wr_q) begin
                        m1_rdata_q <= bus.ctrl_rdata;
                    end
                end else begin
                    m0_done_q <= 1'b1;
                    if (!ctrl_wr_q) begin
                        m0_rdata_q <= bus.ctrl_rdata;
                    end
                end
            end
        end
    end

    assign bus.ctrl_start = ctrl_start_q;
    assign bus.ctrl_wr    = ctrl_wr_q;
    assign bus.ctrl_addr  = ctrl_addr_q;
    assign bus.ctrl_size  = ctrl_size_q;
    assign bus.ctrl_wdata = ctrl_wdata_q;
    assign bus.m0_rdata   = m0_rdata_q;
    assign bus.m1_rdata   = m1_rdata_q;
    assign bus.m0_done    = m0_done_q;
    assign bus.m1_done    = m1_done_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_psram_req_arbiter.sv
// Directed bench for psram_req_arbiter: round-robin/gap-2, fixed-priority and gap-0 instances.
module tb_psram_req_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   starts;

    always #5 clk = ~clk;

    psram_req_arbiter_if #(.AW(24)) ifa ();
    psram_req_arbiter_if #(.AW(24)) ifb ();
    psram_req_arbiter_if #(.AW(24)) ifc ();

    psram_req_arbiter #(.AW(24), .GAP_CYCLES(2), .FIXED_PRIO(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );
    psram_req_arbiter #(.AW(24), .GAP_CYCLES(2), .FIXED_PRIO(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );
    psram_req_arbiter #(.AW(24), .GAP_CYCLES(0), .FIXED_PRIO(0)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ifa.m0_req = 0; ifa.m0_wr = 0; ifa.m0_addr = 0; ifa.m0_size = 0; ifa.m0_wdata = 0;
        ifa.m1_req = 0; ifa.m1_wr = 0; ifa.m1_addr = 0; ifa.m1_size = 0; ifa.m1_wdata = 0;
        ifa.ctrl_rdata = 0; ifa.ctrl_done = 0;
        ifb.m0_req = 0; ifb.m0_wr = 0; ifb.m0_addr = 0; ifb.m0_size = 0; ifb.m0_wdata = 0;
        ifb.m1_req = 0; ifb.m1_wr = 0; ifb.m1_addr = 0; ifb.m1_size = 0; ifb.m1_wdata = 0;
        ifb.ctrl_rdata = 0; ifb.ctrl_done = 0;
        ifc.m0_req = 0; ifc.m0_wr = 0; ifc.m0_addr = 0; ifc.m0_size = 0; ifc.m0_wdata = 0;
        ifc.m1_req = 0; ifc.m1_wr = 0; ifc.m1_addr = 0; ifc.m1_size = 0; ifc.m1_wdata = 0;
        ifc.ctrl_rdata = 0; ifc.ctrl_done = 0;

        // Reset state
        tick();
        tick();
        chk("rst_start", ifa.ctrl_start, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_owner", ifa.owner, 0);
        chk("rst_m0_done", ifa.m0_done, 0);
        chk("rst_addr", ifa.ctrl_addr, 0);
        rst = 0;
        tick();

        // 1: single M0 read, done 6 cycles after start
        ifa.m0_wr = 0; ifa.m0_addr = 24'h000100; ifa.m0_size = 3'd4; ifa.m0_req = 1;
        tick();
        chk("t1_start", ifa.ctrl_start, 1);
        chk("t1_addr", ifa.ctrl_addr, 24'h000100);
        chk("t1_size", ifa.ctrl_size, 4);
        chk("t1_wr", ifa.ctrl_wr, 0);
        chk("t1_busy", ifa.busy, 1);
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            starts += int'(ifa.ctrl_start);
        end
        chk("t1_extra_starts", starts, 0);
        ifa.ctrl_rdata = 32'hDDCCBBAA; ifa.ctrl_done = 1;
        tick();
        chk("t1_m0_done", ifa.m0_done, 1);
        chk("t1_m0_rdata", ifa.m0_rdata, 32'hDDCCBBAA);
        chk("t1_m1_done", ifa.m1_done, 0);
        ifa.ctrl_done = 0; ifa.m0_req = 0;
        tick();
        chk("t1_done_pulse_len", ifa.m0_done, 0);
        chk("t1_rdata_hold", ifa.m0_rdata, 32'hDDCCBBAA);
        tick();
        chk("t1_idle", ifa.busy, 0);

        // Fresh reset so the first tie is the post-reset one
        rst = 1;
        tick();
        rst = 0;
        tick();

        // 2/3: both held for 4 transactions; A round-robin, B fixed priority
        ifa.m0_addr = 24'h000200; ifa.m1_addr = 24'h000300; ifa.m0_size = 4; ifa.m1_size = 4;
        ifb.m0_addr = 24'h000200; ifb.m1_addr = 24'h000300; ifb.m0_size = 4; ifb.m1_size = 4;
        ifa.m0_wr = 0; ifa.m1_wr = 0; ifb.m0_wr = 0; ifb.m1_wr = 0;
        ifa.m0_req = 1; ifa.m1_req = 1; ifb.m0_req = 1; ifb.m1_req = 1;
        tick();
        for (int t = 0; t < 4; t++) begin
            logic exp_a;
            exp_a = (t % 2) == 1;
            chk($sformatf("t3_a_start%0d", t), ifa.ctrl_start, 1);
            chk($sformatf("t3_a_owner%0d", t), ifa.owner, exp_a);
            chk($sformatf("t3_a_addr%0d", t), ifa.ctrl_addr, exp_a ? 24'h000300 : 24'h000200);
            chk($sformatf("t3_b_start%0d", t), ifb.ctrl_start, 1);
            chk($sformatf("t3_b_owner%0d", t), ifb.owner, 0);
            tick();
            ifa.ctrl_rdata = 32'hA0 + t; ifa.ctrl_done = 1;
            ifb.ctrl_rdata = 32'hB0 + t; ifb.ctrl_done = 1;
            tick();
            ifa.ctrl_done = 0; ifb.ctrl_done = 0;
            chk($sformatf("t3_a_m0_done%0d", t), ifa.m0_done, !exp_a);
            chk($sformatf("t3_a_m1_done%0d", t), ifa.m1_done, exp_a);
            chk($sformatf("t3_a_rdata%0d", t), exp_a ? ifa.m1_rdata : ifa.m0_rdata, 32'hA0 + t);
            chk($sformatf("t3_b_m0_done%0d", t), ifb.m0_done, 1);
            chk($sformatf("t3_b_m1_done%0d", t), ifb.m1_done, 0);
            chk($sformatf("t3_b_rdata%0d", t), ifb.m0_rdata, 32'hB0 + t);
            if (t < 3) begin
                tick();
                tick();
                chk($sformatf("t2_gap_nostart%0d", t), ifa.ctrl_start, 0);
                tick();
            end else begin
                ifa.m0_req = 0; ifa.m1_req = 0; ifb.m0_req = 0; ifb.m1_req = 0;
                tick();
                tick();
                tick();
            end
        end
        chk("t3_a_idle", ifa.busy, 0);

        // 4: M1 write; request fields change after grant
        ifa.m1_wr = 1; ifa.m1_addr = 24'h01FFFE; ifa.m1_size = 2; ifa.m1_wdata = 32'h12345678;
        ifa.m1_req = 1;
        tick();
        chk("t4_start", ifa.ctrl_start, 1);
        chk("t4_owner", ifa.owner, 1);
        chk("t4_wr", ifa.ctrl_wr, 1);
        chk("t4_size", ifa.ctrl_size, 2);
        tick();
        ifa.m1_addr = 24'h000000; ifa.m1_wdata = 32'h0; ifa.m1_size = 3'd7;
        tick();
        chk("t4_addr_held", ifa.ctrl_addr, 24'h01FFFE);
        chk("t4_wdata_held", ifa.ctrl_wdata, 32'h12345678);
        tick();
        chk("t4_size_held", ifa.ctrl_size, 2);
        ifa.ctrl_rdata = 32'hFFFFFFFF; ifa.ctrl_done = 1;
        tick();
        chk("t4_m1_done", ifa.m1_done, 1);
        chk("t4_wr_no_rdata", ifa.m1_rdata, 32'hA3);
        chk("t4_wdata_at_done", ifa.ctrl_wdata, 32'h12345678);
        ifa.ctrl_done = 0; ifa.m1_req = 0;

        // 5: gap 0, done coincident with start
        ifc.m0_wr = 0; ifc.m0_addr = 24'h000040; ifc.m0_size = 4; ifc.m0_req = 1;
        tick();
        chk("t5_start", ifc.ctrl_start, 1);
        ifc.ctrl_done = 1; ifc.ctrl_rdata = 32'hCAFEF00D;
        ifc.m1_wr = 0; ifc.m1_addr = 24'h000080; ifc.m1_size = 1; ifc.m1_req = 1;
        tick();
        chk("t5_m0_done", ifc.m0_done, 1);
        chk("t5_m0_rdata", ifc.m0_rdata, 32'hCAFEF00D);
        chk("t5_no_early_start", ifc.ctrl_start, 0);
        ifc.ctrl_done = 0; ifc.m0_req = 0;
        tick();
        chk("t5_next_start", ifc.ctrl_start, 1);
        chk("t5_next_owner", ifc.owner, 1);
        chk("t5_next_addr", ifc.ctrl_addr, 24'h000080);
        tick();
        ifc.ctrl_done = 1; ifc.ctrl_rdata = 32'h5A;
        tick();
        chk("t5_m1_done", ifc.m1_done, 1);
        chk("t5_m1_rdata", ifc.m1_rdata, 32'h5A);
        ifc.ctrl_done = 0; ifc.m1_req = 0;

        // 6: async reset while A is in WAIT
        tick();
        tick();
        ifa.m1_wr = 0; ifa.m1_addr = 24'h000555; ifa.m1_size = 4; ifa.m1_req = 1;
        tick();
        tick();
        chk("t6_busy_before", ifa.busy, 1);
        rst = 1;
        #1;
        chk("t6_start", ifa.ctrl_start, 0);
        chk("t6_addr", ifa.ctrl_addr, 0);
        chk("t6_size", ifa.ctrl_size, 0);
        chk("t6_wdata", ifa.ctrl_wdata, 0);
        chk("t6_m0_rdata", ifa.m0_rdata, 0);
        chk("t6_m1_rdata", ifa.m1_rdata, 0);
        chk("t6_m1_done", ifa.m1_done, 0);
        chk("t6_busy", ifa.busy, 0);
        chk("t6_owner", ifa.owner, 0);
        ifa.m1_req = 0;
        tick();
        rst = 0;
        ifa.ctrl_done = 1; ifa.ctrl_rdata = 32'h77;
        tick();
        ifa.ctrl_done = 0;
        chk("t6_no_m0_done", ifa.m0_done, 0);
        chk("t6_no_m1_done", ifa.m1_done, 0);
        chk("t6_idle", ifa.busy, 0);
        tick();
        chk("t6_no_m1_done2", ifa.m1_done, 0);
        ifa.m0_wr = 0; ifa.m0_addr = 24'h000111; ifa.m0_size = 4;
        ifa.m1_addr = 24'h000222;
        ifa.m0_req = 1; ifa.m1_req = 1;
        tick();
        chk("t6_grant_start", ifa.ctrl_start, 1);
        chk("t6_grant_owner", ifa.owner, 0);
        chk("t6_grant_addr", ifa.ctrl_addr, 24'h000111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
